// File: rtl/branch_resolve_unit.sv
// Purpose: resolves conditional branches from comparator flags, computes target/redirect, flags mispredicts, owns a 2-bit BHT.
// Latency: 1 cycle from accept to out_valid; BHT lookup is combinational, training lands on the retire edge.
// Backpressure: one-entry output register; in_ready = ~flush & (~out_valid | out_ready), fields frozen while stalled.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   flush                          drop held result, block input this cycle
//   in_valid/in_ready              input handshake
//   in_pc, in_imm, in_funct3       branch PC, sign-extended offset, branch type
//   in_pred_taken                  fetch-time prediction
//   ZF, SLTu, SLT                  comparator flags for A vs B
//   out_valid/out_ready            output handshake
//   out_taken, out_target          resolved direction, pc + imm
//   out_mispredict                 resolved direction differs from prediction
//   out_redirect_pc                correct next PC
//   out_illegal                    funct3 is not a branch encoding
//   lookup_pc, lookup_taken        fetch-side BHT read port
module branch_resolve_unit #(
  parameter int          IDX_BITS = 6,
  parameter logic [1:0]  BHT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_imm,
  input  logic [2:0]  in_funct3,
  input  logic        in_pred_taken,
  input  logic        ZF,
  input  logic        SLTu,
  input  logic        SLT,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_taken,
  output logic [31:0] out_target,
  output logic        out_mispredict,
  output logic [31:0] out_redirect_pc,
  output logic        out_illegal,
  input  logic [31:0] lookup_pc,
  output logic        lookup_taken
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          bht [ENTRIES];
  logic [IDX_BITS-1:0] held_idx;   // BHT slot of the branch currently held in the output register
  logic [IDX_BITS-1:0] lookup_idx;
  logic                accept;
  logic                retire_train;
  logic                cond_taken;
  logic                cond_illegal;
  logic [31:0]         target;
  logic [31:0]         fall_thru;
  logic                unused_lookup_bits;

  assign in_ready     = ~flush & (~out_valid | out_ready);
  assign accept       = in_valid & in_ready;
  // A flushed result is thrown away, so it must not train the table either.
  assign retire_train = out_valid & out_ready & ~flush & ~out_illegal;

  assign target    = in_pc + in_imm;
  assign fall_thru = in_pc + 32'd4;

  always_comb begin
    cond_taken   = 1'b0;
    cond_illegal = 1'b0;
    case (in_funct3)
      3'b000:  cond_taken = ZF;
      3'b001:  cond_taken = ~ZF;
      3'b100:  cond_taken = SLT;
      3'b101:  cond_taken = ~SLT;
      3'b110:  cond_taken = SLTu;
      3'b111:  cond_taken = ~SLTu;
      default: cond_illegal = 1'b1;
    endcase
  end

  // No write bypass: a lookup in the training cycle sees the pre-update counter.
  assign lookup_idx         = lookup_pc[IDX_BITS+1:2];
  assign lookup_taken       = bht[lookup_idx][1];
  assign unused_lookup_bits = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_taken       <= 1'b0;
      out_target      <= '0;
      out_mispredict  <= 1'b0;
      out_redirect_pc <= '0;
      out_illegal     <= 1'b0;
      held_idx        <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= BHT_INIT;
      end
    end else begin
      if (retire_train) begin
        if (out_taken && bht[held_idx] != 2'b11) begin
          bht[held_idx] <= bht[held_idx] + 2'd1;
        end else if (!out_taken && bht[held_idx] != 2'b00) begin
          bht[held_idx] <= bht[held_idx] - 2'd1;
        end
      end

      // Data registers only move on accept; flush clears just the valid bit.
      if (accept) begin
        out_taken       <= cond_taken;
        out_target      <= target;
        out_mispredict  <= cond_taken ^ in_pred_taken;
        out_redirect_pc <= cond_taken ? target : fall_thru;
        out_illegal     <= cond_illegal;
        held_idx        <= in_pc[IDX_BITS+1:2];
      end

      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_pred_taken, ZF, SLTu, SLT, out_ready;
  logic [31:0] in_pc, in_imm, lookup_pc;
  logic [2:0]  in_funct3;
  logic        in_ready, out_valid, out_taken, out_mispredict, out_illegal, lookup_taken;
  logic [31:0] out_target, out_redirect_pc;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  bit          m_vld, m_taken, m_misp, m_ill;
  bit [31:0]   m_target, m_redir, m_pc;
  int          m_bht [64];

  always #5 clk = ~clk;

  branch_resolve_unit #(.IDX_BITS(6), .BHT_INIT(2'b01)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_funct3(in_funct3), .in_pred_taken(in_pred_taken),
    .ZF(ZF), .SLTu(SLTu), .SLT(SLT), .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_target(out_target), .out_mispredict(out_mispredict),
    .out_redirect_pc(out_redirect_pc), .out_illegal(out_illegal),
    .lookup_pc(lookup_pc), .lookup_taken(lookup_taken)
  );

  function automatic int idx_of(input bit [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic bit m_lookup(input bit [31:0] pc);
    return m_bht[idx_of(pc)] >= 2;
  endfunction

  function automatic bit m_ready();
    return !flush && (!m_vld || out_ready);
  endfunction

  task automatic idle();
    rst = 0; flush = 0; in_valid = 0; out_ready = 0; in_pred_taken = 0;
    ZF = 0; SLTu = 0; SLT = 0; in_pc = 0; in_imm = 0; in_funct3 = 0; lookup_pc = 0;
  endtask

  task automatic drive(input bit [31:0] pc, input bit [31:0] imm, input bit [2:0] f3,
                       input bit z, input bit lu, input bit ls, input bit pred);
    in_valid = 1; in_pc = pc; in_imm = imm; in_funct3 = f3;
    ZF = z; SLTu = lu; SLT = ls; in_pred_taken = pred;
  endtask

  // One clock edge; the model advances from the inputs held across the edge.
  task automatic tick();
    bit acc, train, tk, ill;
    bit [31:0] pc, tgt;
    acc   = in_valid && m_ready();
    train = m_vld && out_ready && !flush && !m_ill;
    pc = in_pc; tgt = in_pc + in_imm;
    ill = (in_funct3 == 3'd2 || in_funct3 == 3'd3);
    case (in_funct3)
      3'd0: tk = ZF;    3'd1: tk = !ZF;
      3'd4: tk = SLT;   3'd5: tk = !SLT;
      3'd6: tk = SLTu;  3'd7: tk = !SLTu;
      default: tk = 0;
    endcase
    @(posedge clk);
    #1;
    if (rst) begin
      m_vld = 0; m_taken = 0; m_misp = 0; m_ill = 0; m_target = 0; m_redir = 0; m_pc = 0;
      foreach (m_bht[i]) m_bht[i] = 1;
    end else begin
      if (train) begin
        if (m_taken) m_bht[idx_of(m_pc)] = (m_bht[idx_of(m_pc)] == 3) ? 3 : m_bht[idx_of(m_pc)] + 1;
        else         m_bht[idx_of(m_pc)] = (m_bht[idx_of(m_pc)] == 0) ? 0 : m_bht[idx_of(m_pc)] - 1;
      end
      if (acc) begin
        m_taken = tk; m_ill = ill; m_target = tgt; m_misp = tk ^ in_pred_taken;
        m_redir = tk ? tgt : pc + 32'd4; m_pc = pc;
      end
      if (flush) m_vld = 0;
      else if (acc) m_vld = 1;
      else if (out_ready) m_vld = 0;
    end
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if ({out_taken, out_mispredict, out_illegal} !== 3'b000 || out_target !== 0 || out_redirect_pc !== 0) begin
      errors++; $display("FAIL reset_fields got t%b m%b i%b tgt %h rd %h want zeros", out_taken, out_mispredict, out_illegal, out_target, out_redirect_pc);
    end
    for (int i = 0; i < 64; i++) begin
      lookup_pc = 32'(i * 4) | 32'h0000_4000; #1;
      vectors++; if (lookup_taken !== 1'b0) begin errors++; $display("FAIL reset_lookup idx %0d got %b want 0", i, lookup_taken); end
    end
  endtask

  task automatic test_beq_taken();
    idle(); out_ready = 1; drive(32'h1000, 32'h40, 3'b000, 1, 0, 0, 0);
    tick(); in_valid = 0; #1;
    vectors++; if (out_valid !== 1 || out_taken !== 1) begin errors++; $display("FAIL beq_taken got v%b t%b want 1 1", out_valid, out_taken); end
    vectors++; if (out_target !== 32'h1040 || out_redirect_pc !== 32'h1040) begin errors++; $display("FAIL beq_target got %h/%h want 1040/1040", out_target, out_redirect_pc); end
    vectors++; if (out_mispredict !== 1 || out_illegal !== 0) begin errors++; $display("FAIL beq_misp got m%b i%b want 1 0", out_mispredict, out_illegal); end
    tick();
  endtask

  task automatic test_bgeu_wrap();
    idle(); out_ready = 1; drive(32'hFFFF_FFFC, 32'h8, 3'b111, 0, 1, 0, 0);
    tick(); in_valid = 0; #1;
    vectors++; if (out_valid !== 1 || out_taken !== 0 || out_mispredict !== 0) begin errors++; $display("FAIL bgeu_flags got v%b t%b m%b want 1 0 0", out_valid, out_taken, out_mispredict); end
    vectors++; if (out_target !== 32'h4) begin errors++; $display("FAIL bgeu_target got %h want 00000004", out_target); end
    vectors++; if (out_redirect_pc !== 32'h0) begin errors++; $display("FAIL bgeu_redirect got %h want 00000000", out_redirect_pc); end
    tick();
  endtask

  task automatic test_back_to_back();
    idle(); out_ready = 1; drive(32'h500, 32'h100, 3'b001, 0, 0, 0, 1);
    tick(); out_ready = 0; drive(32'h900, 32'h20, 3'b100, 0, 0, 1, 0);
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++; if (in_ready !== 0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", c, in_ready); end
      vectors++; if (out_valid !== 1 || out_target !== 32'h600 || out_taken !== 1 || out_mispredict !== 0) begin
        errors++; $display("FAIL bp_hold cyc %0d got v%b tgt %h t%b m%b want 1 600 1 0", c, out_valid, out_target, out_taken, out_mispredict);
      end
      tick();
    end
    out_ready = 1; #1;
    vectors++; if (in_ready !== 1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick(); in_valid = 0; #1;
    vectors++; if (out_valid !== 1 || out_target !== 32'h920 || out_redirect_pc !== 32'h920 || out_mispredict !== 1) begin
      errors++; $display("FAIL bp_second got v%b tgt %h rd %h m%b want 1 920 920 1", out_valid, out_target, out_redirect_pc, out_mispredict);
    end
    tick(); #1;
    vectors++; if (out_valid !== 0) begin errors++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_bht_saturation();
    bit exp [6] = '{1, 1, 1, 1, 1, 0};
    do_reset(); out_ready = 1; lookup_pc = 32'h2008;
    for (int k = 0; k < 7; k++) begin
      if (k < 6) drive(32'h2008, 32'h10, 3'b100, 0, 0, (k < 4), 1);
      else in_valid = 0;
      tick(); #1;
      if (k >= 1) begin
        vectors++; if (lookup_taken !== exp[k-1]) begin errors++; $display("FAIL bht_sat retire %0d got %b want %b", k, lookup_taken, exp[k-1]); end
      end
    end
  endtask

  task automatic test_flush_illegal();
    do_reset(); out_ready = 1; lookup_pc = 32'h3000;
    drive(32'h3000, 32'h80, 3'b000, 1, 0, 0, 1);
    tick(); flush = 1; drive(32'h7000, 32'h4, 3'b001, 0, 0, 0, 0); #1;
    vectors++; if (in_ready !== 0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    tick(); flush = 0; in_valid = 0; #1;
    vectors++; if (out_valid !== 0 || out_taken !== 1 || out_target !== 32'h3080) begin errors++; $display("FAIL flush_drop got v%b t%b tgt %h want 0 1 3080", out_valid, out_taken, out_target); end
    vectors++; if (lookup_taken !== 0) begin errors++; $display("FAIL flush_no_train got %b want 0", lookup_taken); end
    // Push the counter to 10 so a wrongful not-taken training would show.
    drive(32'h3000, 32'h80, 3'b000, 1, 0, 0, 1); tick(); in_valid = 0; tick(); #1;
    vectors++; if (lookup_taken !== 1) begin errors++; $display("FAIL flush_train_after got %b want 1", lookup_taken); end
    drive(32'h3000, 32'h80, 3'b010, 1, 1, 1, 1); tick(); in_valid = 0; #1;
    vectors++; if (out_illegal !== 1 || out_taken !== 0 || out_mispredict !== 1 || out_redirect_pc !== 32'h3004) begin
      errors++; $display("FAIL illegal_fields got i%b t%b m%b rd %h want 1 0 1 3004", out_illegal, out_taken, out_mispredict, out_redirect_pc);
    end
    tick(); #1;
    vectors++; if (lookup_taken !== 1) begin errors++; $display("FAIL illegal_no_train got %b want 1", lookup_taken); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      in_pc     = ($urandom_range(0, 1) == 1) ? {$urandom} & 32'hFFFF_FFFC : 32'h0000_4000 | (32'($urandom_range(0, 7)) << 2);
      in_imm    = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(16'($urandom)));
      in_funct3 = 3'($urandom_range(0, 7));
      {ZF, SLTu, SLT, in_pred_taken} = 4'($urandom);
      lookup_pc = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0000_4000 | (32'($urandom_range(0, 7)) << 2);
      #1;
      vectors++; if (in_ready !== m_ready()) begin errors++; $display("FAIL rnd_in_ready n %0d got %b want %b", n, in_ready, m_ready()); end
      vectors++; if (lookup_taken !== m_lookup(lookup_pc)) begin errors++; $display("FAIL rnd_lookup n %0d pc %h got %b want %b", n, lookup_pc, lookup_taken, m_lookup(lookup_pc)); end
      tick();
      vectors++; if (out_valid !== m_vld) begin errors++; $display("FAIL rnd_out_valid n %0d got %b want %b", n, out_valid, m_vld); end
      vectors++; if ({out_taken, out_mispredict, out_illegal} !== {m_taken, m_misp, m_ill}) begin
        errors++; $display("FAIL rnd_flags n %0d got t%b m%b i%b want t%b m%b i%b", n, out_taken, out_mispredict, out_illegal, m_taken, m_misp, m_ill);
      end
      vectors++; if (out_target !== m_target || out_redirect_pc !== m_redir) begin
        errors++; $display("FAIL rnd_pcs n %0d got %h/%h want %h/%h", n, out_target, out_redirect_pc, m_target, m_redir);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_beq_taken();
    test_bgeu_wrap();
    test_back_to_back();
    test_bht_saturation();
    test_flush_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Downstream consumer of the 32-bit comparator flags (ZF, SLTu, SLT). It resolves conditional branches from funct3, computes the branch target, and detects mispredicts against the front-end prediction. Results are held in a one-entry valid/ready output register. The block also owns a 2-bit saturating-counter branch history table (BHT) that the fetch stage reads and that is trained on each retired branch.

Parameters:
IDX_BITS, 6, BHT index width; table holds 2^IDX_BITS counters, indexed by pc[IDX_BITS+1:2]
BHT_INIT, 2'b01, counter value loaded on reset (weakly not-taken)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  discard held result and block input this cycle
in_valid  input  1  branch operands/flags valid
in_ready  output  1  unit can accept this cycle
in_pc  input  32  branch instruction PC
in_imm  input  32  sign-extended byte offset
in_funct3  input  3  branch type
in_pred_taken  input  1  prediction made at fetch
ZF  input  1  comparator: A == B
SLTu  input  1  comparator: A < B unsigned
SLT  input  1  comparator: A < B signed
out_valid  output  1  resolved result held
out_ready  input  1  consumer accepts result
out_taken  output  1  branch resolved taken
out_target  output  32  in_pc + in_imm
out_mispredict  output  1  out_taken != in_pred_taken
out_redirect_pc  output  32  correct next PC
out_illegal  output  1  funct3 not a branch
lookup_pc  input  32  fetch-side BHT lookup address
lookup_taken  output  1  MSB of indexed counter

Behaviour:
- Reset (rst=1 at edge): out_valid=0, out_taken=0, out_mispredict=0, out_illegal=0, out_target=0, out_redirect_pc=0. All BHT counters = BHT_INIT. Reset overrides flush and handshakes.
- Condition decode on accept:
  - 000 BEQ: ZF
  - 001 BNE: ~ZF
  - 100 BLT: SLT
  - 101 BGE: ~SLT
  - 110 BLTU: SLTu
  - 111 BGEU: ~SLTu
  - 010/011: taken=0, out_illegal=1; all other codes out_illegal=0.
- Arithmetic: target = in_pc + in_imm, modulo 2^32, wrap-around silent. Fall-through = in_pc + 4, modulo 2^32. out_redirect_pc = taken ? target : fall-through.
- Mispredict: mispredict = taken XOR in_pred_taken, including illegal codes (taken=0).
- Handshake:
  - in_ready = ~flush & (~out_valid | out_ready), combinational.
  - Accept = in_valid & in_ready. Result registers appear with out_valid=1 the next cycle (latency 1).
  - Back-to-back accepts are allowed while out_ready=1, giving full throughput.
  - Output fields stay stable while out_valid & ~out_ready.
  - On out_valid & out_ready with no new accept, out_valid clears next cycle.
- Flush:
  - out_valid=0 next cycle; no accept occurs this cycle.
  - A held result is discarded without BHT training, even if out_ready=1 in the same cycle.
  - Output data registers keep their old values; only out_valid clears.
- BHT training:
  - Occurs when out_valid & out_ready & ~flush & ~out_illegal.
  - Counter at the retired pc[IDX_BITS+1:2] saturates up (max 3) if taken, down (min 0) if not taken. The held PC is registered internally for this.
- BHT lookup: lookup_taken = counter[lookup_pc[IDX_BITS+1:2]][1], combinational. There is no write bypass: lookup in the training cycle returns the pre-update value.
- Reset mid-operation: any held result is lost, and all counters are reinitialised in the same edge.

Test Plan:
- Reset then idle: out_valid=0; lookup_taken=0 for every lookup_pc; in_ready=1.
- BEQ taken: in_pc=0x1000, in_imm=0x40, funct3=000, ZF=1, pred=0, out_ready=1 -> next cycle out_taken=1, out_target=0x1040, out_redirect_pc=0x1040, out_mispredict=1.
- BGEU not taken with wrap: in_pc=0xFFFFFFFC, in_imm=0x8, funct3=111, SLTu=1, pred=0 -> out_taken=0, out_target=0x00000004, out_redirect_pc=0x00000000, out_mispredict=0.
- Backpressure: hold out_ready=0 after one accept -> in_ready=0, outputs frozen for 5 cycles. Then raise out_ready with a second in_valid -> second result appears the following cycle with no bubble.
- BHT saturation: retire 4 taken BLTs at pc=0x2008 -> the index-2 counter goes 01→10→11→11. lookup_taken=1 from the cycle after the first retire. Two not-taken retires -> counter 01, lookup_taken=0.
- Flush and illegal: flush while a taken result is held with out_ready=1 -> out_valid=0 next cycle, counter unchanged. funct3=010 -> out_illegal=1, out_taken=0, no training on retire.
